// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: operation modes, serial negator FSM states
// and the helper that decides whether an operand is to be negated.
package arith_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } sn_state_t;

    localparam int SN_MAX_W = 32;

    // ABS negates only negative operands; the reserved code behaves as PASS.
    function automatic logic neg_eff_of(input mode_t mode, input logic msb);
        logic neg;
        neg = 1'b0;
        case (mode)
            MODE_NEG: neg = 1'b1;
            MODE_ABS: neg = msb;
            default:  neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/serial_negator_if.sv
// Operand/result valid-ready handshake bundle for serial_negator.
// master = producer/consumer side, slave = the negator.
interface serial_negator_if #(
    parameter int W = 8
);
    import arith_pkg::*;

    logic         in_valid;
    logic         in_ready;
    mode_t        mode;
    logic [W-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         ovf;

    modport master (
        output in_valid,
        output mode,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  mode,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out,
        output ovf
    );

endinterface

// File: rtl/serial_comp_cell.sv
// One-bit two's-complement cell: copy bits up to and including the first 1,
// invert every bit after it when negation is in effect.
module serial_comp_cell (
    input  logic bit_in,
    input  logic neg_eff,
    input  logic seen_one,
    output logic bit_out,
    output logic seen_one_nxt
);

    assign bit_out      = bit_in ^ (neg_eff & seen_one);
    assign seen_one_nxt = seen_one | bit_in;

endmodule

// File: rtl/serial_negator.sv
// Bit-serial W-bit negate / absolute-value / pass unit with valid-ready handshakes.
// Build option SERIAL_NEGATOR_SAT_EN: saturate overflowed results to the maximum positive value.
module serial_negator
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    serial_negator_if.slave  bus
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0]  SAT_VAL = {1'b0, {(W-1){1'b1}}};

`ifdef SERIAL_NEGATOR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    sn_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  shift_in_reg;
    logic [W-1:0]  shift_out_reg;
    logic          neg_eff_reg;
    logic          seen_one_reg;
    logic          ovf_reg;

    logic          accept;
    logic          last_bit;
    logic          res_bit;
    logic          seen_one_next;
    logic          ovf_hit;

    serial_comp_cell u_cell (
        .bit_in       (shift_in_reg[0]),
        .neg_eff      (neg_eff_reg),
        .seen_one     (seen_one_reg),
        .bit_out      (res_bit),
        .seen_one_nxt (seen_one_next)
    );

    assign accept   = (state_reg == IDLE) && bus.in_valid;
    assign last_bit = (cnt_reg == LAST);
    // Most-negative operand: the only 1 seen is the sign bit itself.
    assign ovf_hit  = neg_eff_reg && !seen_one_reg && shift_in_reg[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= '0;
            shift_in_reg  <= '0;
            shift_out_reg <= '0;
            neg_eff_reg   <= 1'b0;
            seen_one_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_in_reg <= bus.data_in;
                        cnt_reg      <= '0;
                        seen_one_reg <= 1'b0;
                        ovf_reg      <= 1'b0;
                        neg_eff_reg  <= neg_eff_of(bus.mode, bus.data_in[W-1]);
                    end
                end
                SHIFT: begin
                    shift_in_reg <= shift_in_reg >> 1;
                    seen_one_reg <= seen_one_next;
                    if (!last_bit) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    if (last_bit && ovf_hit && SAT_EN) begin
                        shift_out_reg <= SAT_VAL;
                    end else begin
                        shift_out_reg <= {res_bit, shift_out_reg[W-1:1]};
                    end
                    if (last_bit) begin
                        ovf_reg <= ovf_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.data_out  = shift_out_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_negator.sv
// Directed self-checking bench for serial_negator (W=8 and W=16 instances).
module tb_serial_negator;
    import arith_pkg::*;

`ifdef SERIAL_NEGATOR_SAT_EN
    localparam logic [7:0] EXP_MIN8 = 8'h7F;
`else
    localparam logic [7:0] EXP_MIN8 = 8'h80;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    serial_negator_if #(.W(8))  b8 ();
    serial_negator_if #(.W(16)) b16 ();

    serial_negator #(.W(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));
    serial_negator #(.W(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));

    always @(posedge clk) cyc <= cyc + 1;

    int          acc_cyc[$];
    logic [15:0] res16[$];
    logic        ovf16[$];
    always @(posedge clk) begin
        if (b16.in_valid && b16.in_ready) acc_cyc.push_back(cyc);
        if (b16.out_valid && b16.out_ready) begin
            res16.push_back(b16.data_out);
            ovf16.push_back(b16.ovf);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One W=8 operation; hold = cycles Out_ready is kept low in DONE.
    task automatic run8(input mode_t m, input logic [7:0] d, input logic [7:0] ed,
                        input logic eo, input int hold, input string tag);
        int guard;
        guard = 0;
        while (b8.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk({tag, "_rdy"}, b8.in_ready, 1);
        b8.in_valid = 1'b1;
        b8.mode     = m;
        b8.data_in  = d;
        tick();
        b8.in_valid = 1'b0;
        b8.mode     = MODE_PASS;
        b8.data_in  = ~d;
        chk({tag, "_busy"}, b8.in_ready, 0);
        repeat (6) tick();
        tick();
        chk({tag, "_lat_lo"}, b8.out_valid, 0);
        tick();
        chk({tag, "_lat_hi"}, b8.out_valid, 1);
        chk({tag, "_data"}, b8.data_out, ed);
        chk({tag, "_ovf"}, b8.ovf, eo);
        for (int i = 0; i < hold; i++) begin
            b8.in_valid = (i == 2);
            b8.mode     = MODE_NEG;
            b8.data_in  = 8'h11;
            tick();
            chk({tag, "_hold_vld"}, b8.out_valid, 1);
            chk({tag, "_hold_data"}, b8.data_out, ed);
            chk({tag, "_hold_ovf"}, b8.ovf, eo);
            chk({tag, "_hold_rdy"}, b8.in_ready, 0);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, b8.in_ready, 1);
        chk({tag, "_idle_vld"}, b8.out_valid, 0);
    endtask

    initial begin
        int guard;
        reset_n       = 1'b1;
        b8.in_valid   = 1'b0;
        b8.mode       = MODE_PASS;
        b8.data_in    = '0;
        b8.out_ready  = 1'b0;
        b16.in_valid  = 1'b0;
        b16.mode      = MODE_PASS;
        b16.data_in   = '0;
        b16.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", b8.in_ready, 1);
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_data_out", b8.data_out, 0);
        chk("rst_ovf", b8.ovf, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run8(MODE_NEG,  8'h05, 8'hFB,    1'b0, 0, "neg05");
        run8(MODE_NEG,  8'h80, EXP_MIN8, 1'b1, 0, "neg80");
        run8(MODE_NEG,  8'h00, 8'h00,    1'b0, 0, "neg00");
        run8(MODE_ABS,  8'hFB, 8'h05,    1'b0, 0, "absFB");
        run8(MODE_ABS,  8'h05, 8'h05,    1'b0, 0, "abs05");
        run8(MODE_RSVD, 8'hA5, 8'hA5,    1'b0, 0, "rsvdA5");
        run8(MODE_PASS, 8'h3C, 8'h3C,    1'b0, 0, "pass3C");
        run8(MODE_ABS,  8'h80, EXP_MIN8, 1'b1, 0, "abs80");
        run8(MODE_NEG,  8'h6C, 8'h94,    1'b0, 5, "bp6C");

        // Abort mid-SHIFT once cnt has reached 3.
        b8.in_valid = 1'b1;
        b8.mode     = MODE_NEG;
        b8.data_in  = 8'h5A;
        tick();
        b8.in_valid = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_in_ready", b8.in_ready, 1);
        chk("abort_out_valid", b8.out_valid, 0);
        chk("abort_data_out", b8.data_out, 0);
        chk("abort_ovf", b8.ovf, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run8(MODE_NEG, 8'h01, 8'hFF, 1'b0, 0, "neg01");

        // W=16 back-to-back with Out_ready tied high.
        b16.out_ready = 1'b1;
        b16.mode      = MODE_NEG;
        b16.data_in   = 16'h1234;
        b16.in_valid  = 1'b1;
        guard = 0;
        while (acc_cyc.size() < 1 && guard < 60) begin
            tick();
            guard++;
        end
        b16.data_in = 16'h0001;
        guard = 0;
        while (acc_cyc.size() < 2 && guard < 60) begin
            tick();
            guard++;
        end
        b16.in_valid = 1'b0;
        guard = 0;
        while (res16.size() < 2 && guard < 60) begin
            tick();
            guard++;
        end
        chk("w16_n_acc", acc_cyc.size(), 2);
        chk("w16_n_res", res16.size(), 2);
        if (acc_cyc.size() >= 2) chk("w16_spacing", acc_cyc[1] - acc_cyc[0], 18);
        if (res16.size() >= 2) begin
            chk("w16_res0", res16[0], 16'hEDCC);
            chk("w16_ovf0", ovf16[0], 0);
            chk("w16_res1", res16[1], 16'hFFFF);
            chk("w16_ovf1", ovf16[1], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
